// File: rtl/csa_pkg.sv
// Shared constants for the carry-save adder datapath and its downstream accumulator.
// Keeping the W/E defaults here means carry_save_adder and csa_sum_accumulator
// always agree on the beat width.
//   CSA_W, CSA_E     : CSA input width and bit extension
//   CSA_ACC_W        : default accumulator width
//   CSA_CNT_W        : default beat-counter width
//   IN_W             : width of one reduced CSA beat, {cout, sum}
//   csa_state_e      : accumulator FSM state encoding
package csa_pkg;

  localparam int unsigned CSA_W     = 4;
  localparam int unsigned CSA_E     = 5;
  localparam int unsigned CSA_ACC_W = 16;
  localparam int unsigned CSA_CNT_W = 8;
  localparam int unsigned IN_W      = CSA_W + CSA_E + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } csa_state_e;

endpackage

// File: rtl/csa_sum_accumulator_if.sv
// Handshake bundle between the CSA stage, the accumulator and the activation stage.
//   in_valid/in_ready   : upstream beat handshake
//   in_sum, in_cout     : CSA result, beat value is {in_cout, in_sum}
//   in_last             : marks the final beat of a packet
//   out_valid/out_ready : downstream result handshake
//   out_data, out_count : packet total and saturating beat count
//   overflow            : accumulator carried out during the packet
// Modports: master drives the beats and out_ready; slave is the accumulator.
interface csa_sum_accumulator_if
  import csa_pkg::*;
#(
  parameter int unsigned W     = CSA_W,
  parameter int unsigned E     = CSA_E,
  parameter int unsigned ACC_W = CSA_ACC_W,
  parameter int unsigned CNT_W = CSA_CNT_W
);

  logic             in_valid;
  logic             in_ready;
  logic [W+E-1:0]   in_sum;
  logic             in_cout;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             overflow;

  modport master (
    output in_valid, in_sum, in_cout, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, overflow
  );

  modport slave (
    input  in_valid, in_sum, in_cout, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, overflow
  );

endinterface

// File: rtl/csa_acc_add.sv
// Zero-extending accumulator adder: sum_o = acc_i + value_i over ACC_W bits.
//   acc_i   : current accumulator
//   value_i : IN_W-bit unsigned beat value
//   sum_o   : ACC_W-bit result (wrapped, or clamped when CSA_ACC_SAT_EN is defined)
//   carry_o : carry out of the ACC_W-bit add
// Optional build macro: CSA_ACC_SAT_EN clamps sum_o to all-ones on carry-out.
module csa_acc_add #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned IN_W  = 10
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [IN_W-1:0]  value_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             carry_o
);

  logic [ACC_W:0] raw;

  always_comb begin
    raw     = {1'b0, acc_i} + (ACC_W + 1)'(value_i);
    carry_o = raw[ACC_W];
`ifdef CSA_ACC_SAT_EN
    // Once clamped, any further non-zero beat carries again, so the clamp holds.
    sum_o   = carry_o ? '1 : raw[ACC_W-1:0];
`else
    sum_o   = raw[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/csa_sum_accumulator.sv
// Accumulates reduced CSA beats {cout, sum} across a packet and presents the
// packet total on a valid/ready handshake.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : csa_sum_accumulator_if.slave (beat input, result output)
// Optional build macro: CSA_ACC_SAT_EN (saturating accumulator, see csa_acc_add).
// One bubble follows every result since in_ready is low while holding it.
module csa_sum_accumulator
  import csa_pkg::*;
#(
  parameter int unsigned W     = CSA_W,
  parameter int unsigned E     = CSA_E,
  parameter int unsigned ACC_W = CSA_ACC_W,
  parameter int unsigned CNT_W = CSA_CNT_W
) (
  input logic                  clk,
  input logic                  rst_n,
  csa_sum_accumulator_if.slave bus
);

  localparam int unsigned BeatW = W + E + 1;

  csa_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             in_ready;
  logic             accept;
  logic [BeatW-1:0] beat;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;

  assign beat     = {bus.in_cout, bus.in_sum};
  assign in_ready = (state_q != HOLD);
  assign accept   = bus.in_valid & in_ready;

  csa_acc_add #(
    .ACC_W (ACC_W),
    .IN_W  (BeatW)
  ) u_add (
    .acc_i   (acc_q),
    .value_i (beat),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = ACC_W'(beat);
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = bus.in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = add_sum;
          // Count sticks at all-ones; accumulation carries on regardless.
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          ovf_d = ovf_q | add_carry;
          if (bus.in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = acc_q;
  assign bus.out_count = cnt_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_csa_sum_accumulator.sv
module tb_csa_sum_accumulator;

  localparam int unsigned W     = 4;
  localparam int unsigned E     = 5;
  localparam int unsigned ACC_W = 16;
  localparam int unsigned CNT_W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  csa_sum_accumulator_if #(.W(W), .E(E), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  csa_sum_accumulator #(
    .W     (W),
    .E     (E),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one beat at edge+1 and returns at edge+1 after it was clocked in.
  task automatic send_beat(input logic cout, input logic [W+E-1:0] sum, input logic last);
    bus.in_valid = 1'b1;
    bus.in_cout  = cout;
    bus.in_sum   = sum;
    bus.in_last  = last;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== 16'd0) begin errors++;
      $display("FAIL reset_out_data: got %0d expected 0", bus.out_data); end
    checks++; if (bus.out_count !== 8'd0) begin errors++;
      $display("FAIL reset_out_count: got %0d expected 0", bus.out_count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++;
      $display("FAIL reset_overflow: got %0b expected 0", bus.overflow); end
  endtask

  task automatic test_three_beats();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.in_ready !== 1'b1) begin errors++;
        $display("FAIL t1_in_ready_beat%0d: got %0b expected 1", i, bus.in_ready); end
      send_beat(1'b0, 9'd480, i == 2);
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++;
      $display("FAIL t1_out_valid: got %0b expected 1", bus.out_valid); end
    checks++; if (bus.out_data !== 16'd1440) begin errors++;
      $display("FAIL t1_out_data: got %0d expected 1440", bus.out_data); end
    checks++; if (bus.out_count !== 8'd3) begin errors++;
      $display("FAIL t1_out_count: got %0d expected 3", bus.out_count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++;
      $display("FAIL t1_overflow: got %0b expected 0", bus.overflow); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++;
      $display("FAIL t1_bubble: got in_ready %0b expected 0", bus.in_ready); end
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL t1_after: got in_ready %0b out_valid %0b expected 1 0",
               bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_cout_weight();
    bus.out_ready = 1'b1;
    send_beat(1'b1, 9'd0, 1'b1);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd512) begin errors++;
      $display("FAIL t2_data: got valid %0b data %0d expected 1 512",
               bus.out_valid, bus.out_data); end
    checks++; if (bus.out_count !== 8'd1) begin errors++;
      $display("FAIL t2_count: got %0d expected 1", bus.out_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    send_beat(1'b0, 9'd7, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sum   = 9'd99;
      bus.in_last  = 1'b1;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd7) begin errors++;
        $display("FAIL t3_hold%0d: got valid %0b data %0d expected 1 7",
                 i, bus.out_valid, bus.out_data); end
      checks++; if (bus.in_ready !== 1'b0 || bus.out_count !== 8'd1) begin errors++;
        $display("FAIL t3_stall%0d: got in_ready %0b count %0d expected 0 1",
                 i, bus.in_ready, bus.out_count); end
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    checks++; if (bus.out_data !== 16'd7 || bus.out_count !== 8'd1) begin errors++;
      $display("FAIL t3_stable: got data %0d count %0d expected 7 1",
               bus.out_data, bus.out_count); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL t3_release: got valid %0b in_ready %0b expected 0 1",
               bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_data;
`ifdef CSA_ACC_SAT_EN
    exp_data = 16'd65535;
`else
    exp_data = 16'd224;
`endif
    bus.out_ready = 1'b1;
    for (int i = 0; i < 137; i++) send_beat(1'b0, 9'd480, i == 136);
    checks++; if (bus.out_data !== exp_data) begin errors++;
      $display("FAIL t4_data: got %0d expected %0d", bus.out_data, exp_data); end
    checks++; if (bus.overflow !== 1'b1) begin errors++;
      $display("FAIL t4_overflow: got %0b expected 1", bus.overflow); end
    checks++; if (bus.out_count !== 8'd137) begin errors++;
      $display("FAIL t4_count: got %0d expected 137", bus.out_count); end
    @(posedge clk); #1;
    send_beat(1'b0, 9'd5, 1'b1);
    checks++; if (bus.overflow !== 1'b0 || bus.out_data !== 16'd5) begin errors++;
      $display("FAIL t4_next: got overflow %0b data %0d expected 0 5",
               bus.overflow, bus.out_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_count_sat();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) send_beat(1'b0, 9'd1, i == 299);
    checks++; if (bus.out_count !== 8'd255) begin errors++;
      $display("FAIL cnt_sat_count: got %0d expected 255", bus.out_count); end
    checks++; if (bus.out_data !== 16'd300 || bus.overflow !== 1'b0) begin errors++;
      $display("FAIL cnt_sat_data: got data %0d overflow %0b expected 300 0",
               bus.out_data, bus.overflow); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_packet();
    bus.out_ready = 1'b1;
    send_beat(1'b0, 9'd100, 1'b0);
    send_beat(1'b0, 9'd100, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL t5_reset: got valid %0b in_ready %0b expected 0 1",
               bus.out_valid, bus.in_ready); end
    checks++; if (bus.out_data !== 16'd0) begin errors++;
      $display("FAIL t5_cleared: got %0d expected 0", bus.out_data); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL t5_no_output: got valid %0b expected 0", bus.out_valid); end
    send_beat(1'b0, 9'd5, 1'b1);
    checks++; if (bus.out_data !== 16'd5 || bus.out_count !== 8'd1) begin errors++;
      $display("FAIL t5_next: got data %0d count %0d expected 5 1",
               bus.out_data, bus.out_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_gaps();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_beat(1'b0, 9'd15, i == 3);
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          bus.in_sum  = 9'($urandom);
          bus.in_cout = 1'($urandom);
          bus.in_last = 1'($urandom);
          @(posedge clk); #1;
        end
        bus.in_last = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++;
          $display("FAIL t6_gap%0d: got valid %0b expected 0", i, bus.out_valid); end
      end
    end
    checks++; if (bus.out_data !== 16'd60 || bus.out_count !== 8'd4) begin errors++;
      $display("FAIL t6_result: got data %0d count %0d expected 60 4",
               bus.out_data, bus.out_count); end
    @(posedge clk); #1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.in_cout   = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    test_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_three_beats();
    test_cout_weight();
    test_backpressure();
    test_overflow();
    test_count_sat();
    test_reset_mid_packet();
    test_gaps();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csa_sum_accumulator.md
Name: csa_sum_accumulator

Overview:
Downstream stage of carry_save_adder. Takes one reduced CSA result per beat, {cout, sum}, and accumulates it across a packet of beats, e.g. the channel/kernel-slice partial sums of one CNN output pixel. Emits the packet total over a valid/ready handshake to the activation/requantisation stage.

Parameters:
W, 4, CSA input data width (must match carry_save_adder W)
E, 5, CSA bit extension (must match carry_save_adder E)
ACC_W, 16, accumulator/result width; must be >= W+E+1
CNT_W, 8, beat-counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream beat valid
in_ready  out  1  accumulator can accept a beat
in_sum  in  W+E  CSA sum
in_cout  in  1  CSA carry-out (MSB of beat value)
in_last  in  1  final beat of packet
out_valid  out  1  packet result valid
out_ready  in  1  downstream accepts result
out_data  out  ACC_W  accumulated packet total
out_count  out  CNT_W  beats in packet (saturating)
overflow  out  1  accumulator exceeded ACC_W bits during this packet

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous active-low. Reset forces state IDLE, acc=0, count=0, overflow=0, out_valid=0, out_data=0, out_count=0. in_ready is combinational from state, so it is 1 during reset.
- Beat value: {in_cout, in_sum}, W+E+1 bits unsigned, zero-extended to ACC_W. A beat is accepted when in_valid && in_ready.
- FSM states:
  - IDLE: in_ready=1. On accept: acc=value, count=1, overflow=0. If in_last go to HOLD, else go to ACCUM.
  - ACCUM: in_ready=1. On accept: acc=acc+value; count=count+1, saturating at 2^CNT_W-1; overflow|=carry out of the ACC_W add. If in_last go to HOLD. With no accept, hold all state.
  - HOLD: in_ready=0, out_valid=1. out_data=acc, out_count=count and overflow are stable until the handshake. On out_ready go to IDLE and clear out_valid the next cycle.
- Latency: out_valid rises the cycle after the last beat is accepted. One mandatory bubble follows each result, because in_ready=0 in HOLD. Sustained rate is one packet per (beats+1) cycles.
- Wrap: without the optional feature, acc wraps modulo 2^ACC_W and overflow is sticky for the packet. overflow clears on the first beat of the next packet.
- Counter: reaching 2^CNT_W-1 does not stop accumulation; out_count sticks at its maximum.
- in_last with in_valid low is ignored. Input fields are don't-care when in_valid=0.
- out_ready while not in HOLD is ignored.
- Reset mid-packet discards the partial sum and returns to IDLE. No output is produced for the discarded packet.
- Registered outputs: out_valid, out_data, out_count, overflow. in_ready is combinational from state only, with no input-to-output combinational path.

Optional Feature:
- Macro CSA_ACC_SAT_EN.
- Defined: on add carry-out, acc clamps to 2^ACC_W-1 and stays clamped for the rest of the packet; overflow is still set.
- Undefined: modulo wrap as described under Behaviour.

Decomposition:
- Package csa_pkg holds:
  - localparam IN_W = W+E+1;
  - state encoding IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2;
  - the shared W/E defaults, so carry_save_adder and this block agree.
- One sub-module, csa_acc_add: zero-extending ACC_W adder. It returns the sum and carry-out and applies saturation under CSA_ACC_SAT_EN. The FSM, counter and handshake stay in the top.

Test Plan:
1. Three beats of 480 (in_cout=0, in_sum=480), in_last on the third, out_ready=1 -> out_valid one cycle later; out_data=1440, out_count=3, overflow=0; in_ready=0 for exactly one cycle.
2. Single beat in_cout=1, in_sum=0, in_last=1 -> out_data=512, out_count=1; checks cout weighting.
3. Backpressure: result 7 ready, out_ready=0 for 5 cycles -> out_valid held, out_data stable at 7, in_ready=0 and offered beats not accepted; out_ready=1 -> IDLE next cycle.
4. Overflow, ACC_W=16: 137 beats of 480 = 65760 -> out_data=224, overflow=1. With CSA_ACC_SAT_EN -> out_data=65535, overflow=1. A following 1-beat packet of 5 -> overflow=0.
5. Reset mid-packet: 2 beats of 100, then rst_n low 1 cycle -> out_valid=0, state IDLE; next packet {5, last} -> out_data=5, out_count=1.
6. Gaps: 4 beats of 15 with in_valid low 3 cycles between beats -> out_data=60, out_count=4; random in_sum while in_valid=0 has no effect.
